// File: rtl/light_conflict_monitor.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// light_conflict_monitor
//
// Safety stage sitting between the 4-way phase sequencer and the lamp drivers.
// Lamp buses are one-hot: 100 = red, 010 = yellow, 001 = green.
// Incoming buses are sampled into stage 1, checked there against per-approach
// history, and forwarded from stage 2 to the drivers (two-cycle latency).
// Any detected fault replaces all lamps with flashing red until an operator
// clear, followed by a solid all-red recovery interval.
//
// Ports:
//   clk                     system clock, rising edge
//   rst_a                   asynchronous active-high reset
//   n/s/e/w_lights_in [2:0] lamp buses from the sequencer
//   clr_fault               operator clear (pulse or level, used only in FAULT)
//   n/s/e/w_lights_out[2:0] registered lamp drive
//   fault                   high from fault entry until monitoring resumes
//   fault_code [2:0]        latched cause: 0 none, 1 invalid, 2 conflict,
//                           3 illegal transition, 4 short yellow, 5 stuck green
//   flash                   high while flashing red
// ----------------------------------------------------------------------------
module light_conflict_monitor #(
    parameter int MIN_YEL    = 3,
    parameter int MAX_GRN    = 16,
    parameter int FILT       = 2,
    parameter int FLASH_HALF = 4,
    parameter int ALL_RED    = 8
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_lights_in,
    input  logic [2:0] s_lights_in,
    input  logic [2:0] e_lights_in,
    input  logic [2:0] w_lights_in,
    input  logic       clr_fault,
    output logic [2:0] n_lights_out,
    output logic [2:0] s_lights_out,
    output logic [2:0] e_lights_out,
    output logic [2:0] w_lights_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam logic [1:0] ST_MONITOR = 2'd0;
    localparam logic [1:0] ST_FAULT   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_INVALID  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_TRANS    = 3'd3;
    localparam logic [2:0] CODE_SHORTYEL = 3'd4;
    localparam logic [2:0] CODE_STUCKGRN = 3'd5;

    localparam int RUN_MAX = (MIN_YEL > MAX_GRN + 1) ? MIN_YEL : MAX_GRN + 1;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int FILT_W  = $clog2(FILT + 1);
    localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int AR_W    = (ALL_RED > 1) ? $clog2(ALL_RED) : 1;

    localparam logic [RUN_W-1:0]   RUN_SAT    = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0]   YEL_MIN    = RUN_W'(MIN_YEL);
    localparam logic [RUN_W-1:0]   GRN_MAX    = RUN_W'(MAX_GRN);
    localparam logic [FILT_W-1:0]  FILT_SAT   = FILT_W'(FILT);
    localparam logic [FILT_W-1:0]  FILT_PRE   = FILT_W'(FILT - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);
    localparam logic [AR_W-1:0]    AR_LAST    = AR_W'(ALL_RED - 1);

    // Approach index order everywhere: 0 = north, 1 = south, 2 = east, 3 = west
    logic [2:0]         w_in     [4];
    logic [2:0]         r_s1     [4];
    logic [2:0]         r_prev   [4];
    logic [RUN_W-1:0]   r_yelCnt [4];
    logic [RUN_W-1:0]   r_grnCnt [4];
    logic [2:0]         r_out    [4];
    logic [FILT_W-1:0]  r_invCnt;
    logic [FILT_W-1:0]  r_cnfCnt;
    logic [1:0]         r_state;
    logic               r_fault;
    logic               r_flash;
    logic               r_flashPhase;
    logic [2:0]         r_code;
    logic [FLASH_W-1:0] r_flashCnt;
    logic [AR_W-1:0]    r_arCnt;

    logic       w_invalid;
    logic       w_conflict;
    logic       w_trans;
    logic       w_shortYel;
    logic       w_stuckGrn;
    logic [3:0] w_nonRed;
    logic       w_invFire;
    logic       w_cnfFire;
    logic [2:0] w_code;
    logic       w_anyFault;
    logic       w_recoverExit;

    assign w_in[0] = n_lights_in;
    assign w_in[1] = s_lights_in;
    assign w_in[2] = e_lights_in;
    assign w_in[3] = w_lights_in;

    assign n_lights_out = r_out[0];
    assign s_lights_out = r_out[1];
    assign e_lights_out = r_out[2];
    assign w_lights_out = r_out[3];
    assign fault        = r_fault;
    assign fault_code   = r_code;
    assign flash        = r_flash;

    // Pattern checks on the stage-1 sample. Yellow/green run counters hold the
    // run length up to and including the previous sample, so a red arriving
    // after yellow sees exactly how many yellow samples preceded it.
    always_comb begin
        w_invalid  = 1'b0;
        w_trans    = 1'b0;
        w_shortYel = 1'b0;
        w_stuckGrn = 1'b0;
        w_nonRed   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (!((r_s1[i] == RED) || (r_s1[i] == YEL) || (r_s1[i] == GRN)))
                w_invalid = 1'b1;
            w_nonRed[i] = (r_s1[i] == YEL) || (r_s1[i] == GRN);
            if (((r_prev[i] == GRN) && (r_s1[i] == RED)) ||
                ((r_prev[i] == RED) && (r_s1[i] == YEL)) ||
                ((r_prev[i] == YEL) && (r_s1[i] == GRN)))
                w_trans = 1'b1;
            if ((r_prev[i] == YEL) && (r_s1[i] == RED) && (r_yelCnt[i] < YEL_MIN))
                w_shortYel = 1'b1;
            if ((r_s1[i] == GRN) && (r_grnCnt[i] >= GRN_MAX))
                w_stuckGrn = 1'b1;
        end
    end

    // More than one bit set in w_nonRed means two approaches are showing
    // yellow/green at once.
    assign w_conflict = (w_nonRed & (w_nonRed - 4'd1)) != 4'd0;
    assign w_invFire  = w_invalid  && (r_invCnt >= FILT_PRE);
    assign w_cnfFire  = w_conflict && (r_cnfCnt >= FILT_PRE);

    // Only the highest-priority cause is reported when several coincide.
    always_comb begin
        w_code = CODE_NONE;
        if (w_invFire)       w_code = CODE_INVALID;
        else if (w_cnfFire)  w_code = CODE_CONFLICT;
        else if (w_trans)    w_code = CODE_TRANS;
        else if (w_shortYel) w_code = CODE_SHORTYEL;
        else if (w_stuckGrn) w_code = CODE_STUCKGRN;
    end

    assign w_anyFault    = (r_state == ST_MONITOR) && (w_code != CODE_NONE);
    assign w_recoverExit = (r_state == ST_RECOVER) && (r_arCnt == AR_LAST) &&
                           !w_invalid && !w_conflict;

    // Stage 1: unconditional sample of the sequencer buses.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            for (int i = 0; i < 4; i++) r_s1[i] <= RED;
        end else begin
            for (int i = 0; i < 4; i++) r_s1[i] <= w_in[i];
        end
    end

    // Per-approach history and filter counters. They only track while
    // monitoring; leaving recovery reseeds them from the clean sample that
    // allowed the exit so the first monitored transition is judged fairly.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            for (int i = 0; i < 4; i++) begin
                r_prev[i]   <= RED;
                r_yelCnt[i] <= '0;
                r_grnCnt[i] <= '0;
            end
            r_invCnt <= '0;
            r_cnfCnt <= '0;
        end else if (w_recoverExit) begin
            for (int i = 0; i < 4; i++) begin
                r_prev[i]   <= r_s1[i];
                r_yelCnt[i] <= '0;
                r_grnCnt[i] <= '0;
            end
            r_invCnt <= '0;
            r_cnfCnt <= '0;
        end else if (r_state == ST_MONITOR) begin
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= r_s1[i];
                if (r_s1[i] == YEL)
                    r_yelCnt[i] <= (r_yelCnt[i] == RUN_SAT) ? RUN_SAT : r_yelCnt[i] + RUN_W'(1);
                else
                    r_yelCnt[i] <= '0;
                if (r_s1[i] == GRN)
                    r_grnCnt[i] <= (r_grnCnt[i] == RUN_SAT) ? RUN_SAT : r_grnCnt[i] + RUN_W'(1);
                else
                    r_grnCnt[i] <= '0;
            end
            if (w_invalid)
                r_invCnt <= (r_invCnt == FILT_SAT) ? FILT_SAT : r_invCnt + FILT_W'(1);
            else
                r_invCnt <= '0;
            if (w_conflict)
                r_cnfCnt <= (r_cnfCnt == FILT_SAT) ? FILT_SAT : r_cnfCnt + FILT_W'(1);
            else
                r_cnfCnt <= '0;
        end
    end

    // Supervisory FSM and stage 2. A fault detected on the current stage-1
    // sample turns the lamps red on the same edge that would have forwarded
    // that sample, so an immediate fault never reaches the drivers. The flash
    // phase flips on the wrap edge; the new phase decides the lamp level.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_state      <= ST_MONITOR;
            r_fault      <= 1'b0;
            r_flash      <= 1'b0;
            r_code       <= CODE_NONE;
            r_flashCnt   <= '0;
            r_flashPhase <= 1'b0;
            r_arCnt      <= '0;
            for (int i = 0; i < 4; i++) r_out[i] <= RED;
        end else begin
            case (r_state)
                ST_MONITOR: begin
                    if (w_anyFault) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_flash      <= 1'b1;
                        r_code       <= w_code;
                        r_flashCnt   <= '0;
                        r_flashPhase <= 1'b0;
                        for (int i = 0; i < 4; i++) r_out[i] <= RED;
                    end else begin
                        for (int i = 0; i < 4; i++) r_out[i] <= r_s1[i];
                    end
                end
                ST_FAULT: begin
                    if (clr_fault) begin
                        r_state <= ST_RECOVER;
                        r_flash <= 1'b0;
                        r_arCnt <= '0;
                        for (int i = 0; i < 4; i++) r_out[i] <= RED;
                    end else if (r_flashCnt == FLASH_LAST) begin
                        r_flashCnt   <= '0;
                        r_flashPhase <= ~r_flashPhase;
                        for (int i = 0; i < 4; i++) r_out[i] <= r_flashPhase ? RED : DARK;
                    end else begin
                        r_flashCnt <= r_flashCnt + FLASH_W'(1);
                    end
                end
                ST_RECOVER: begin
                    for (int i = 0; i < 4; i++) r_out[i] <= RED;
                    if (w_recoverExit) begin
                        r_state <= ST_MONITOR;
                        r_fault <= 1'b0;
                        r_code  <= CODE_NONE;
                    end else if (r_arCnt != AR_LAST) begin
                        r_arCnt <= r_arCnt + AR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_MONITOR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_light_conflict_monitor
//
// Directed bench for light_conflict_monitor. Lamp vectors are packed as
// {north, south, east, west}, 3 bits each. Expected values are hand-derived
// from the intended behaviour: every edge forwards the sample taken on the
// previous edge, and a fault switches the lamps to red on the edge after the
// offending sample.
// ----------------------------------------------------------------------------
module tb_light_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;
    localparam logic [2:0] BAD = 3'b011;

    typedef struct {
        logic [11:0] drive;
        logic [11:0] expOut;
        logic        expFault;
        logic [2:0]  expCode;
        logic        expFlash;
    } vec_t;

    logic       clk;
    logic       rst_a;
    logic [2:0] nIn, sIn, eIn, wIn;
    logic       clrFault;
    logic [2:0] nOut, sOut, eOut, wOut;
    logic       faultOut;
    logic [2:0] codeOut;
    logic       flashOut;

    int nCompared;
    int nMismatched;

    vec_t        tbl [19];
    logic [11:0] prevDrive;
    logic [11:0] v;

    light_conflict_monitor dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .n_lights_in  (nIn),
        .s_lights_in  (sIn),
        .e_lights_in  (eIn),
        .w_lights_in  (wIn),
        .clr_fault    (clrFault),
        .n_lights_out (nOut),
        .s_lights_out (sOut),
        .e_lights_out (eOut),
        .w_lights_out (wOut),
        .fault        (faultOut),
        .fault_code   (codeOut),
        .flash        (flashOut)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One approach set to the given lamp, all others red.
    function automatic logic [11:0] approachVec(input int a, input logic [2:0] lamp);
        logic [11:0] r;
        r = {R, R, R, R};
        r[11 - 3*a -: 3] = lamp;
        return r;
    endfunction

    // Drive one input vector, let one rising edge pass, settle just after it.
    task automatic applyStimulus(input logic [11:0] vec, input logic clr);
        {nIn, sIn, eIn, wIn} = vec;
        clrFault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic compareField(input string name, input logic [11:0] act, input logic [11:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [11:0] expOut,
                               input logic expFault, input logic [2:0] expCode,
                               input logic expFlash);
        compareField({name, ".lamps"}, {nOut, sOut, eOut, wOut}, expOut);
        compareField({name, ".fault"}, {11'd0, faultOut}, {11'd0, expFault});
        compareField({name, ".code"},  {9'd0, codeOut},   {9'd0, expCode});
        compareField({name, ".flash"}, {11'd0, flashOut}, {11'd0, expFlash});
    endtask

    // Reset pulse placed in the low clock phase, away from rising edges.
    task automatic resetDut();
        @(negedge clk);
        rst_a    = 1'b1;
        {nIn, sIn, eIn, wIn} = {R, R, R, R};
        clrFault = 1'b0;
        #2;
        rst_a = 1'b0;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_a       = 1'b1;
        clrFault    = 1'b0;
        {nIn, sIn, eIn, wIn} = {R, R, R, R};

        // Filter pass (single conflicting overlap), legal yellow of exactly
        // MIN_YEL, then a two-sample conflict that faults with code 010.
        tbl[0]  = '{{R,R,R,R}, {R,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{{G,R,R,R}, {R,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{{G,R,R,R}, {G,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{{Y,R,R,R}, {G,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{{Y,R,R,R}, {Y,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{{Y,R,G,R}, {Y,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{{R,R,G,R}, {Y,R,G,R}, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{{R,R,G,R}, {R,R,G,R}, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{{R,R,Y,R}, {R,R,G,R}, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{{R,R,Y,R}, {R,R,Y,R}, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{{R,R,Y,R}, {R,R,Y,R}, 1'b0, 3'd0, 1'b0};
        tbl[11] = '{{R,R,R,R}, {R,R,Y,R}, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{{R,R,R,R}, {R,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[13] = '{{R,R,R,R}, {R,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{{G,R,R,R}, {R,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[15] = '{{Y,R,R,R}, {G,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[16] = '{{Y,R,G,R}, {Y,R,R,R}, 1'b0, 3'd0, 1'b0};
        tbl[17] = '{{Y,R,G,R}, {Y,R,G,R}, 1'b0, 3'd0, 1'b0};
        tbl[18] = '{{Y,R,G,R}, {R,R,R,R}, 1'b1, 3'd2, 1'b1};

        // Reset values while reset is held.
        #2;
        checkOutput("reset", {R,R,R,R}, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_a = 1'b0;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].drive, 1'b0);
            checkOutput($sformatf("tbl[%0d]", i), tbl[i].expOut, tbl[i].expFault,
                        tbl[i].expCode, tbl[i].expFlash);
        end

        // Free-running flash: entry edge was the first red cycle, so three
        // more red, four dark, then red again. Conflicting input is ignored.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus({G,R,G,R}, 1'b0);
            checkOutput($sformatf("flash[%0d]", k), (k >= 4 && k <= 7) ? {D,D,D,D} : {R,R,R,R},
                        1'b1, 3'd2, 1'b1);
        end

        // Clear with legal input: solid red while the all-red counter runs,
        // monitoring resumes on the eighth edge after the clear.
        applyStimulus({R,R,R,R}, 1'b1);
        checkOutput("clr1", {R,R,R,R}, 1'b1, 3'd2, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus({R,R,R,R}, 1'b0);
            checkOutput($sformatf("allred[%0d]", k), {R,R,R,R}, 1'b1, 3'd2, 1'b0);
        end
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("resume1", {R,R,R,R}, 1'b0, 3'd0, 1'b0);

        // Green straight to red on north: illegal transition, never shown.
        applyStimulus({G,R,R,R}, 1'b0);
        checkOutput("trans.a", {R,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("trans.b", {G,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("trans.fault", {R,R,R,R}, 1'b1, 3'd3, 1'b1);

        // Clear while the input keeps conflicting: recovery must hold.
        applyStimulus({G,R,G,R}, 1'b1);
        checkOutput("clr2", {R,R,R,R}, 1'b1, 3'd3, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus({G,R,G,R}, 1'b0);
            checkOutput($sformatf("hold[%0d]", k), {R,R,R,R}, 1'b1, 3'd3, 1'b0);
        end
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("hold.last", {R,R,R,R}, 1'b1, 3'd3, 1'b0);
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("resume2", {R,R,R,R}, 1'b0, 3'd0, 1'b0);

        // Short yellow: two yellow samples then red.
        resetDut();
        applyStimulus({G,R,R,R}, 1'b0);
        checkOutput("shorty.a", {R,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({Y,R,R,R}, 1'b0);
        checkOutput("shorty.b", {G,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({Y,R,R,R}, 1'b0);
        checkOutput("shorty.c", {Y,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("shorty.d", {Y,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("shorty.fault", {R,R,R,R}, 1'b1, 3'd4, 1'b1);
        for (int k = 1; k <= 4; k++) applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("shorty.dark", {D,D,D,D}, 1'b1, 3'd4, 1'b1);

        // Asynchronous reset in the dark half of the flash.
        #2;
        rst_a = 1'b1;
        #1;
        checkOutput("asyncrst", {R,R,R,R}, 1'b0, 3'd0, 1'b0);
        rst_a = 1'b0;

        // Two full legal sequencer rounds: output is the previous drive.
        prevDrive = {R,R,R,R};
        for (int round = 0; round < 2; round++) begin
            for (int a = 0; a < 4; a++) begin
                for (int k = 0; k < 12; k++) begin
                    v = approachVec(a, (k < 8) ? G : Y);
                    applyStimulus(v, 1'b0);
                    checkOutput($sformatf("legal[%0d.%0d.%0d]", round, a, k), prevDrive,
                                1'b0, 3'd0, 1'b0);
                    prevDrive = v;
                end
            end
        end
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("legal.tail", prevDrive, 1'b0, 3'd0, 1'b0);

        // Stuck green: sample 17 of continuous green faults, sample 16 does not.
        resetDut();
        for (int k = 1; k <= 17; k++) begin
            applyStimulus({G,R,R,R}, 1'b0);
            checkOutput($sformatf("stuck[%0d]", k), (k == 1) ? {R,R,R,R} : {G,R,R,R},
                        1'b0, 3'd0, 1'b0);
        end
        applyStimulus({G,R,R,R}, 1'b0);
        checkOutput("stuck.fault", {R,R,R,R}, 1'b1, 3'd5, 1'b1);

        // Invalid encoding and conflict together: invalid wins.
        resetDut();
        applyStimulus({BAD,G,G,R}, 1'b0);
        checkOutput("prio.a", {R,R,R,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({BAD,G,G,R}, 1'b0);
        checkOutput("prio.b", {BAD,G,G,R}, 1'b0, 3'd0, 1'b0);
        applyStimulus({R,R,R,R}, 1'b0);
        checkOutput("prio.fault", {R,R,R,R}, 1'b1, 3'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
